// File: rtl/filtro_pkg.sv
// Shared types, saturation helper and address map for the DF2 IIR filter.
package filtro_pkg;

    typedef enum logic [2:0] {IDLE, FB, NORM, FF, OUT} state_e;

    typedef enum logic [2:0] {
        MAC_HOLD, MAC_LOAD, MAC_MUL, MAC_ADD, MAC_SUB
    } mac_op_e;

    // Wide enough for every intermediate of any legal configuration
    localparam int SAT_W = 128;

    function automatic int acc_width(input int w, input int n);
        return 2 * w + $clog2(2 * n + 2);
    endfunction

    function automatic int addr_width(input int n);
        return $clog2(2 * n + 1);
    endfunction

    // b_k lives at k, a_k lives at n+k
    function automatic int a_addr(input int n, input int k);
        return n + k;
    endfunction

    function automatic int addr_max(input int n);
        return 2 * n;
    endfunction

    localparam int ACC_W_DEF = acc_width(32, 2);
    localparam int ADDR_W_DEF = addr_width(2);

    function automatic logic signed [SAT_W-1:0] sat(
        input logic signed [SAT_W-1:0] value,
        input int w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/filtro_iir_df2_param_mac.sv
// Single-cycle signed W x W multiply with wide accumulate/subtract.
module mac_punto_fijo
    import filtro_pkg::*;
#(
    parameter int W     = 32,
    parameter int ACC_W = 67
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  mac_op_e                 op,
    input  logic signed [W-1:0]     a,
    input  logic signed [W-1:0]     b,
    input  logic signed [ACC_W-1:0] load_val,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_x;

    assign prod   = (2 * W)'(a) * (2 * W)'(b);
    assign prod_x = ACC_W'(prod);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            unique case (op)
                MAC_LOAD: acc <= load_val;
                MAC_MUL:  acc <= prod_x;
                MAC_ADD:  acc <= acc + prod_x;
                MAC_SUB:  acc <= acc - prod_x;
                default:  acc <= acc;
            endcase
        end
    end

endmodule

// File: rtl/filtro_iir_df2_param.sv
// Time-multiplexed Direct Form II IIR filter of order N on one MAC,
// with a runtime coefficient bank and saturation reporting.
module filtro_iir_df2_param
    import filtro_pkg::*;
#(
    parameter  int W     = 32,
    parameter  int FRAC  = 16,
    parameter  int N     = 2,
    localparam int ACC_W = acc_width(W, N),
    localparam int AW    = addr_width(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] xd1,
    input  logic signed [W-1:0] xd2,
    input  logic                coef_we,
    input  logic [AW-1:0]       coef_addr,
    input  logic signed [W-1:0] coef_data,
    output logic                out_valid,
    output logic signed [W-1:0] y,
    output logic                sat_flag
);

    localparam int CNT_W = 4;
    localparam logic signed [W-1:0] ONE = W'(1) << FRAC;

    state_e state, state_d;
    mac_op_e mac_op;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic live;
    logic flag;
    logic accept, coef_ok;
    int idx;

    logic signed [W-1:0] coef [0:2*N];
    logic signed [W-1:0] dly [1:N];
    logic signed [W-1:0] w0;
    logic signed [W-1:0] op_a, op_b;
    logic signed [ACC_W-1:0] acc, load_val;
    logic signed [SAT_W-1:0] sum_x, x_sat;
    logic signed [SAT_W-1:0] w0_raw, w0_sat, y_raw, y_sat;

    // live keeps in_ready low until the first edge after reset release
    assign in_ready = live && (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign coef_ok  = coef_we && in_ready &&
                      (coef_addr <= AW'(addr_max(N)));

    always_comb begin
        sum_x    = SAT_W'(xd1) + SAT_W'(xd2);
        x_sat    = sat(sum_x, W);
        load_val = ACC_W'(W'(x_sat)) <<< FRAC;
        w0_raw   = SAT_W'(acc) >>> FRAC;
        w0_sat   = sat(w0_raw, W);
        y_raw    = SAT_W'(acc) >>> FRAC;
        y_sat    = sat(y_raw, W);
    end

    always_comb begin
        op_a = '0;
        op_b = '0;
        idx  = (state == FB) ? a_addr(N, int'(cnt)) : int'(cnt);
        for (int i = 0; i <= 2 * N; i++)
            if (idx == i) op_a = coef[i];
        if (cnt == '0) op_b = w0;
        for (int i = 1; i <= N; i++)
            if (int'(cnt) == i) op_b = dly[i];
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        mac_op  = MAC_HOLD;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_d = FB;
                    cnt_d   = CNT_W'(1);
                    mac_op  = MAC_LOAD;
                end
            end
            FB: begin
                mac_op = MAC_SUB;
                if (cnt == CNT_W'(N)) state_d = NORM;
                else cnt_d = cnt + CNT_W'(1);
            end
            NORM: begin
                state_d = FF;
                cnt_d   = '0;
            end
            FF: begin
                mac_op = (cnt == '0) ? MAC_MUL : MAC_ADD;
                if (cnt == CNT_W'(N)) state_d = OUT;
                else cnt_d = cnt + CNT_W'(1);
            end
            OUT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            live      <= 1'b0;
            w0        <= '0;
            flag      <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            sat_flag  <= 1'b0;
            for (int i = 0; i <= 2 * N; i++) coef[i] <= '0;
            coef[0] <= ONE;
            for (int i = 1; i <= N; i++) dly[i] <= '0;
        end else begin
            live      <= 1'b1;
            state     <= state_d;
            cnt       <= cnt_d;
            out_valid <= 1'b0;
            if (coef_ok)
                for (int i = 0; i <= 2 * N; i++)
                    if (coef_addr == AW'(i)) coef[i] <= coef_data;
            if (accept) flag <= (x_sat != sum_x);
            if (state == NORM) begin
                w0   <= W'(w0_sat);
                flag <= flag | (w0_sat != w0_raw);
            end
            if (state == OUT) begin
                y         <= W'(y_sat);
                out_valid <= 1'b1;
                sat_flag  <= flag | (y_sat != y_raw);
                dly[1]    <= w0;
                for (int i = 2; i <= N; i++) dly[i] <= dly[i-1];
            end
        end
    end

    mac_punto_fijo #(.W(W), .ACC_W(ACC_W)) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (mac_op),
        .a        (op_a),
        .b        (op_b),
        .load_val (load_val),
        .acc      (acc)
    );

endmodule

// File: tb/tb_filtro_iir_df2_param.sv
// Self-checking bench for filtro_iir_df2_param against a plain-arithmetic model.
module tb_filtro_iir_df2_param;

    localparam int W = 32;
    localparam int FRAC = 16;
    localparam int N = 2;
    localparam int AW = 3;

    typedef logic signed [127:0] big_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [W-1:0] xd1 = '0;
    logic [W-1:0] xd2 = '0;
    logic coef_we = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [W-1:0] coef_data = '0;
    logic out_valid;
    logic [W-1:0] y;
    logic sat_flag;

    int n_checks = 0;
    int n_fail = 0;

    big_t mb [0:N];
    big_t ma [1:N];
    big_t mw [1:N];

    always #5 clk = ~clk;

    filtro_iir_df2_param #(.W(W), .FRAC(FRAC), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .xd1       (xd1),
        .xd2       (xd2),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .y         (y),
        .sat_flag  (sat_flag)
    );

    function automatic big_t msat(input big_t v);
        big_t hi, lo;
        hi = 128'sd2147483647;
        lo = -128'sd2147483648;
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k <= N; k++) mb[k] = 0;
        for (int k = 1; k <= N; k++) begin
            ma[k] = 0;
            mw[k] = 0;
        end
        mb[0] = 65536;
    endtask

    task automatic model_coef(input int addr, input logic [W-1:0] d);
        if (addr <= N) mb[addr] = big_t'($signed(d));
        else if (addr <= 2 * N) ma[addr-N] = big_t'($signed(d));
    endtask

    task automatic model_step(input logic [W-1:0] x1, input logic [W-1:0] x2,
                              output logic [W-1:0] ye, output logic fe);
        big_t s, x, w0, yv;
        s = big_t'($signed(x1)) + big_t'($signed(x2));
        x = msat(s);
        fe = (x != s);
        s = x * 65536;
        for (int k = 1; k <= N; k++) s = s - ma[k] * mw[k];
        s = s >>> FRAC;
        w0 = msat(s);
        fe = fe | (w0 != s);
        s = mb[0] * w0;
        for (int k = 1; k <= N; k++) s = s + mb[k] * mw[k];
        s = s >>> FRAC;
        yv = msat(s);
        fe = fe | (yv != s);
        for (int k = N; k >= 2; k--) mw[k] = mw[k-1];
        mw[1] = w0;
        ye = yv[W-1:0];
    endtask

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        coef_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks += 4;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_in_ready: got %b required 0", in_ready);
        end
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_out_valid: got %b required 0", out_valid);
        end
        if (y !== '0) begin
            n_fail++;
            $display("FAIL rst_y: got %h required 0", y);
        end
        if (sat_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_sat_flag: got %b required 0", sat_flag);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_ready: got %b required 1", in_ready);
        end
        model_reset();
    endtask

    task automatic write_coef(input int addr, input logic [W-1:0] d);
        wait_ready();
        coef_we = 1'b1;
        coef_addr = addr[AW-1:0];
        coef_data = d;
        @(posedge clk);
        #1 coef_we = 1'b0;
        model_coef(addr, d);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (out_valid !== 1'b1 && lat < 40);
    endtask

    task automatic send(input logic [W-1:0] x1, input logic [W-1:0] x2,
                        output logic [W-1:0] gy, output logic gf,
                        output int lat);
        wait_ready();
        in_valid = 1'b1;
        xd1 = x1;
        xd2 = x2;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(lat);
        gy = y;
        gf = sat_flag;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_passthrough();
        logic [W-1:0] gy, ye;
        logic gf, fe;
        int lat;
        send(32'h0001_0000, 32'h0000_8000, gy, gf, lat);
        model_step(32'h0001_0000, 32'h0000_8000, ye, fe);
        n_checks += 3;
        if (lat != 7) begin
            n_fail++;
            $display("FAIL pass_latency: got %0d required 7", lat);
        end
        if (gy !== 32'h0001_8000) begin
            n_fail++;
            $display("FAIL pass_y: got %h required 00018000", gy);
        end
        if (gf !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_flag: got %b required 0", gf);
        end
    endtask

    task automatic test_decay();
        logic [W-1:0] xin [4] = '{32'h0001_0000, 0, 0, 0};
        logic [W-1:0] exp_y [4] = '{32'h8000, 32'h4000, 32'h2000, 32'h1000};
        logic [W-1:0] gy, ye;
        logic gf, fe;
        int lat;
        do_reset();
        write_coef(0, 32'h0000_8000);
        write_coef(3, 32'hFFFF_8000);
        for (int i = 0; i < 4; i++) begin
            send(xin[i], 0, gy, gf, lat);
            model_step(xin[i], 0, ye, fe);
            n_checks++;
            if (gy !== exp_y[i]) begin
                n_fail++;
                $display("FAIL decay_y[%0d]: got %h required %h", i, gy, exp_y[i]);
            end
        end
    endtask

    task automatic test_fir();
        logic [W-1:0] xin [4] = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 0};
        logic [W-1:0] exp_y [4] = '{32'h0001_0000, 32'h0003_0000,
                                    32'h0006_0000, 32'h0005_0000};
        logic [W-1:0] gy, ye;
        logic gf, fe;
        int lat;
        do_reset();
        write_coef(1, 32'h0001_0000);
        write_coef(2, 32'h0001_0000);
        for (int i = 0; i < 4; i++) begin
            send(xin[i], 0, gy, gf, lat);
            model_step(xin[i], 0, ye, fe);
            n_checks++;
            if (gy !== exp_y[i]) begin
                n_fail++;
                $display("FAIL fir_y[%0d]: got %h required %h", i, gy, exp_y[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] xin [3] = '{32'h7FFF_FFFF, 32'h8000_0000, 0};
        logic [W-1:0] exp_y [3] = '{32'h7FFF_FFFF, 32'h8000_0000, 0};
        logic exp_f [3] = '{1'b1, 1'b1, 1'b0};
        logic [W-1:0] gy, ye;
        logic gf, fe;
        int lat;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(xin[i], xin[i], gy, gf, lat);
            model_step(xin[i], xin[i], ye, fe);
            n_checks += 2;
            if (gy !== exp_y[i]) begin
                n_fail++;
                $display("FAIL sat_y[%0d]: got %h required %h", i, gy, exp_y[i]);
            end
            if (gf !== exp_f[i]) begin
                n_fail++;
                $display("FAIL sat_flag[%0d]: got %b required %b", i, gf, exp_f[i]);
            end
        end
    endtask

    task automatic test_coef_gating();
        logic [W-1:0] gy, ye;
        logic gf, fe;
        int lat;
        int busy_ready = 0;
        wait_ready();
        in_valid = 1'b1;
        xd1 = 32'h0003_0000;
        xd2 = 0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        model_step(32'h0003_0000, 0, ye, fe);
        coef_we = 1'b1;
        coef_addr = 0;
        coef_data = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0) busy_ready++;
        end
        coef_we = 1'b0;
        wait_out(lat);
        n_checks += 2;
        if (busy_ready != 0) begin
            n_fail++;
            $display("FAIL busy_ready: got %0d ready cycles required 0", busy_ready);
        end
        if (y !== ye) begin
            n_fail++;
            $display("FAIL busy_write_y: got %h required %h", y, ye);
        end
        write_coef(5, 0);
        write_coef(7, 0);
        send(32'h0001_0000, 0, gy, gf, lat);
        model_step(32'h0001_0000, 0, ye, fe);
        n_checks++;
        if (gy !== 32'h0001_0000) begin
            n_fail++;
            $display("FAIL oor_write_y: got %h required 00010000", gy);
        end
        wait_ready();
        coef_we = 1'b1;
        coef_addr = 0;
        coef_data = 32'h0002_0000;
        in_valid = 1'b1;
        xd1 = 32'h0001_0000;
        xd2 = 0;
        @(posedge clk);
        #1 begin
            coef_we = 1'b0;
            in_valid = 1'b0;
        end
        model_coef(0, 32'h0002_0000);
        model_step(32'h0001_0000, 0, ye, fe);
        wait_out(lat);
        n_checks++;
        if (y !== 32'h0002_0000) begin
            n_fail++;
            $display("FAIL same_edge_write_y: got %h required 00020000", y);
        end
        write_coef(0, 32'h0001_0000);
    endtask

    task automatic test_back_to_back();
        int acc_cyc [3];
        int acc_n = 0;
        int outs = 0;
        int busy = 0;
        logic [W-1:0] q [$];
        logic [W-1:0] ye, exp_v;
        logic fe;
        in_valid = 1'b1;
        xd1 = 32'h0004_0000;
        xd2 = 32'h0000_1234;
        for (int c = 0; c < 80 && outs < 3; c++) begin
            @(negedge clk);
            if (acc_n == 3) in_valid = 1'b0;
            if (out_valid === 1'b1 && q.size() > 0) begin
                exp_v = q.pop_front();
                outs++;
                n_checks++;
                if (y !== exp_v) begin
                    n_fail++;
                    $display("FAIL b2b_y[%0d]: got %h required %h", outs, y, exp_v);
                end
            end
            if (acc_n >= 1 && acc_n < 3 && in_ready !== 1'b1) busy++;
            if (in_valid && in_ready === 1'b1) begin
                acc_cyc[acc_n] = c;
                acc_n++;
                model_step(xd1, xd2, ye, fe);
                q.push_back(ye);
            end
        end
        in_valid = 1'b0;
        n_checks += 4;
        if (acc_n != 3 || outs != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d accepts %0d outputs required 3 3",
                     acc_n, outs);
        end
        if (acc_n == 3 && acc_cyc[1] - acc_cyc[0] != 8) begin
            n_fail++;
            $display("FAIL b2b_gap0: got %0d required 8", acc_cyc[1] - acc_cyc[0]);
        end
        if (acc_n == 3 && acc_cyc[2] - acc_cyc[1] != 8) begin
            n_fail++;
            $display("FAIL b2b_gap1: got %0d required 8", acc_cyc[2] - acc_cyc[1]);
        end
        if (busy != 14) begin
            n_fail++;
            $display("FAIL b2b_busy: got %0d not-ready cycles required 14", busy);
        end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] gy, ye;
        logic gf, fe;
        int lat;
        int ov = 0;
        int ybad = 0;
        write_coef(0, 32'h0000_8000);
        send(32'h0001_0000, 0, gy, gf, lat);
        model_step(32'h0001_0000, 0, ye, fe);
        wait_ready();
        in_valid = 1'b1;
        xd1 = 32'h0001_0000;
        xd2 = 0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ov++;
            if (y !== '0) ybad++;
        end
        n_checks += 2;
        if (ov != 0) begin
            n_fail++;
            $display("FAIL abort_out_valid: got %0d pulses required 0", ov);
        end
        if (ybad != 0) begin
            n_fail++;
            $display("FAIL abort_y: got %0d nonzero cycles required 0", ybad);
        end
        send(32'h0001_0000, 0, gy, gf, lat);
        model_step(32'h0001_0000, 0, ye, fe);
        n_checks += 2;
        if (gy !== 32'h0001_0000) begin
            n_fail++;
            $display("FAIL abort_next_y: got %h required 00010000", gy);
        end
        if (lat != 7) begin
            n_fail++;
            $display("FAIL abort_latency: got %0d required 7", lat);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] gy, ye, x1, x2, d;
        logic gf, fe;
        int lat;
        do_reset();
        for (int a = 0; a <= 2 * N; a++) begin
            if (a <= N) d = $urandom_range(0, 32'h0002_0000) - 32'h0001_0000;
            else d = $urandom_range(0, 32'h0001_0000) - 32'h0000_8000;
            write_coef(a, d);
        end
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                x1 = $urandom;
                x2 = $urandom;
            end else begin
                x1 = $urandom_range(0, 32'h0008_0000) - 32'h0004_0000;
                x2 = $urandom_range(0, 32'h0008_0000) - 32'h0004_0000;
            end
            send(x1, x2, gy, gf, lat);
            model_step(x1, x2, ye, fe);
            n_checks += 3;
            if (gy !== ye) begin
                n_fail++;
                $display("FAIL rand_y[%0d]: got %h required %h", i, gy, ye);
            end
            if (gf !== fe) begin
                n_fail++;
                $display("FAIL rand_flag[%0d]: got %b required %b", i, gf, fe);
            end
            if (lat != 7) begin
                n_fail++;
                $display("FAIL rand_latency[%0d]: got %0d required 7", i, lat);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_passthrough();
        test_decay();
        test_fir();
        test_saturation();
        test_coef_gating();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
